// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// stream field order and the default memory depth used to size mem_interface.
package inst_loader_pkg;

    localparam int          STATE_W           = 4;
    localparam logic [15:0] DEFAULT_MEM_DEPTH = 16'd4096;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CSUM    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    // Order in which fields appear on the byte stream.
    typedef enum logic [1:0] {
        FLD_LEN_HI = 2'd0,
        FLD_LEN_LO = 2'd1,
        FLD_DATA   = 2'd2,
        FLD_CSUM   = 2'd3
    } field_t;

    function automatic logic accepts_byte(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_byte_pair.sv
// Pairs stream bytes into a 16-bit word (high byte first) and keeps a running
// XOR of every accepted byte for the trailing checksum compare.
module loader_byte_pair (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic        sel_hi,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic [7:0]  csum
);

    logic [7:0] hi_q;
    logic [7:0] lo_q;
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= 8'd0;
            lo_q   <= 8'd0;
            csum_q <= 8'd0;
        end else if (clear) begin
            csum_q <= 8'd0;
        end else if (accept) begin
            csum_q <= csum_q ^ byte_in;
            if (sel_hi) begin
                hi_q <= byte_in;
            end else begin
                lo_q <= byte_in;
            end
        end
    end

    assign word = {hi_q, lo_q};
    assign csum = csum_q;

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction memory writer: parses a length-prefixed byte stream,
// writes 16-bit words and releases the CPU only after the checksum matches.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'd0,
    parameter logic [15:0] MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] mem_wraddress,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    state_t      state;
    state_t      state_next;
    logic        fire;
    logic        start_fire;
    logic [15:0] len_q;
    logic [15:0] len_next;
    logic [15:0] wr_addr;
    logic [15:0] pair_word;
    logic [7:0]  csum;
    logic        pair_accept;
    logic        pair_sel_hi;

    assign in_ready    = accepts_byte(state);
    assign fire        = in_valid && in_ready;
    assign start_fire  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_next    = {len_q[15:8], in_data};
    // The checksum byte itself is compared, never folded into the accumulator.
    assign pair_accept = fire && (state != ST_CSUM);
    assign pair_sel_hi = (state == ST_LEN_HI) || (state == ST_DATA_HI);

    loader_byte_pair u_pair (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_fire),
        .accept  (pair_accept),
        .sel_hi  (pair_sel_hi),
        .byte_in (in_data),
        .word    (pair_word),
        .csum    (csum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (fire) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (fire) begin
                    if (len_next > MEM_DEPTH) begin
                        state_next = ST_ERR;
                    end else if (len_next == 16'd0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (fire) state_next = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (fire) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = ((words_loaded + 16'd1) == len_q) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: begin
                if (fire) state_next = (in_data == csum) ? ST_DONE : ST_ERR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= 16'd0;
            wr_addr      <= 16'd0;
            words_loaded <= 16'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= BOOT_HOLD;
        end else begin
            if (start_fire) begin
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= 16'd0;
                cpu_hold     <= 1'b1;
            end
            if ((state == ST_LEN_HI) && fire) len_q[15:8] <= in_data;
            if ((state == ST_LEN_LO) && fire) len_q[7:0]  <= in_data;
            if ((state == ST_DATA_LO) && fire) wr_addr <= BASE_ADDR + words_loaded;
            if (state == ST_WRITE) words_loaded <= words_loaded + 16'd1;
            // An aborted load keeps the CPU held so a partial image never runs.
            if ((state != ST_ERR) && (state_next == ST_ERR)) error <= 1'b1;
            if ((state == ST_CSUM) && (state_next == ST_DONE)) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

    assign mem_wren      = (state == ST_WRITE);
    assign mem_wraddress = wr_addr;
    assign mem_data      = pair_word;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: write pulses are checked against a
// scoreboard queue filled as each word is streamed in.
module tb_inst_loader;

    localparam logic [15:0] BASE      = 16'd0;
    localparam logic [15:0] DEPTH     = 16'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] mem_wraddress;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [15:0] stream_words[$];

    inst_loader #(
        .BASE_ADDR (BASE),
        .MEM_DEPTH (DEPTH),
        .BOOT_HOLD (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_wraddress (mem_wraddress),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest outstanding word.
    always @(negedge clk) begin
        if (!rst && mem_wren) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_wren: got addr=%h data=%h, required no write",
                         mem_wraddress, mem_data);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if ({mem_wraddress, mem_data} !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL wr_word: got addr=%h data=%h, required addr=%h data=%h",
                             mem_wraddress, mem_data, exp[31:16], exp[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waitc = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("[TB] FAIL handshake_timeout: byte %h not accepted after %0d cycles, required acceptance",
                     b, waitc);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stream(input logic [15:0] n, input bit corrupt, input bit gaps);
        logic [7:0]  cs;
        logic [15:0] w;
        cs = n[15:8] ^ n[7:0];
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        if (n <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                w = stream_words[i];
                sb.push_back({BASE + 16'(i), w});
                cs = cs ^ w[15:8] ^ w[7:0];
                send_byte(w[15:8], gaps);
                send_byte(w[7:0], gaps);
            end
            send_byte(corrupt ? (cs ^ 8'h01) : cs, gaps);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cpu_hold, done, error, mem_wren, in_ready} !== 5'b10000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got hold/done/err/wren/rdy=%b, required 10000",
                     {cpu_hold, done, error, mem_wren, in_ready});
        end
        n_checks++;
        if ({words_loaded, mem_wraddress, mem_data} !== 48'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: got wl=%h addr=%h data=%h, required all zero",
                     words_loaded, mem_wraddress, mem_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal_load();
        stream_words = '{16'h1234, 16'hABCD};
        do_start();
        n_checks++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_len_hi: got rdy=%b hold=%b, required 1 1", in_ready, cpu_hold);
        end
        send_stream(16'd2, 1'b0, 1'b0);
        n_checks++;
        if ({done, error, cpu_hold, words_loaded} !== {3'b100, 16'd2}) begin
            n_fail++;
            $display("[TB] FAIL normal_status: got done=%b err=%b hold=%b wl=%0d, required 1 0 0 2",
                     done, error, cpu_hold, words_loaded);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL normal_writes: got %0d writes missing, required 0", sb.size());
        end
    endtask

    task automatic test_bad_checksum();
        stream_words = '{16'h1234, 16'hABCD};
        do_start();
        n_checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL restart_clear: got done=%b hold=%b, required 0 1", done, cpu_hold);
        end
        send_stream(16'd2, 1'b1, 1'b0);
        n_checks++;
        if ({done, error, cpu_hold, in_ready} !== 4'b0110) begin
            n_fail++;
            $display("[TB] FAIL bad_csum_status: got done/err/hold/rdy=%b, required 0110",
                     {done, error, cpu_hold, in_ready});
        end
        n_checks++;
        if (sb.size() != 0 || words_loaded !== 16'd2) begin
            n_fail++;
            $display("[TB] FAIL bad_csum_writes: got pending=%0d wl=%0d, required 0 and 2",
                     sb.size(), words_loaded);
        end
    endtask

    task automatic test_zero_and_oversize();
        do_start();
        send_stream(16'd0, 1'b0, 1'b0);
        n_checks++;
        if ({done, error, cpu_hold, words_loaded} !== {3'b100, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL zero_len: got done=%b err=%b hold=%b wl=%0d, required 1 0 0 0",
                     done, error, cpu_hold, words_loaded);
        end
        do_start();
        send_stream(DEPTH + 16'd1, 1'b0, 1'b0);
        n_checks++;
        if ({done, error, cpu_hold, in_ready, words_loaded} !== {4'b0110, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL oversize: got done/err/hold/rdy=%b wl=%0d, required 0110 0",
                     {done, error, cpu_hold, in_ready}, words_loaded);
        end
        n_checks++;
        if (mem_wren !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL oversize_wren: got %b, required 0", mem_wren);
        end
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 3; pass++) begin
            stream_words.delete();
            for (int i = 0; i < 4; i++) stream_words.push_back(16'($urandom));
            do_start();
            send_stream(16'd4, 1'b0, 1'b1);
            n_checks++;
            if ({done, error, cpu_hold, words_loaded} !== {3'b100, 16'd4} || sb.size() != 0) begin
                n_fail++;
                $display("[TB] FAIL gaps_pass%0d: got done=%b err=%b hold=%b wl=%0d pending=%0d, required 1 0 0 4 0",
                         pass, done, error, cpu_hold, words_loaded, sb.size());
            end
        end
    endtask

    task automatic test_reset_mid_load();
        stream_words = '{16'hBEEF, 16'hCAFE, 16'hF00D};
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        sb.push_back({BASE, 16'hBEEF});
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, done, error, cpu_hold, mem_wren, words_loaded} !== {5'b00010, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got rdy/done/err/hold/wren=%b wl=%0d, required 00010 0",
                     {in_ready, done, error, cpu_hold, mem_wren}, words_loaded);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_first_word: got %0d pending, required 0", sb.size());
        end
        do_start();
        send_stream(16'd3, 1'b0, 1'b0);
        n_checks++;
        if ({done, error, cpu_hold, words_loaded} !== {3'b100, 16'd3} || sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL reload: got done=%b err=%b hold=%b wl=%0d pending=%0d, required 1 0 0 3 0",
                     done, error, cpu_hold, words_loaded, sb.size());
        end
    endtask

    initial begin
        $display("[TB] inst_loader bench start");
        test_reset();
        test_normal_load();
        test_bad_checksum();
        test_zero_and_oversize();
        test_back_to_back();
        test_reset_mid_load();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
